// File: rtl/f1_light_monitor.sv
// F1 start-light monitor: checks the thermometer light bar fills 0..N then goes out, and times the press.
// Optional macro BTN_SYNC_EN: btn passes through a 2-flop synchronizer ahead of btn_q.
module f1_light_monitor #(
  parameter int N_LIGHTS = 8,
  parameter int TIME_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_LIGHTS-1:0] lights_in,
  input  logic                btn,
  input  logic                ack,
  output logic [3:0]          level,
  output logic                busy,
  output logic [TIME_W-1:0]   result,
  output logic                result_valid,
  output logic                timeout,
  output logic                err,
  output logic [1:0]          err_cause
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMING = 3'd1;
  localparam logic [2:0] S_FULL   = 3'd2;
  localparam logic [2:0] S_TIMING = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_CODE = 2'b01;
  localparam logic [1:0] CAUSE_SEQ  = 2'b10;
  localparam logic [1:0] CAUSE_JUMP = 2'b11;

  localparam logic [TIME_W-1:0] CNT_MAX  = '1;
  localparam logic [TIME_W-1:0] CNT_ONE  = TIME_W'(1);
  localparam logic [3:0]        LVL_FULL = 4'(N_LIGHTS);

  logic [N_LIGHTS-1:0] lights_q;
  logic                btn_q;
  logic                btn_prev_q;
  logic                btn_src;
  logic [3:0]          level_prev_q;

  logic [2:0]          state_q, state_d;
  logic [TIME_W-1:0]   cnt_q, cnt_d;
  logic [TIME_W-1:0]   result_q, result_d;
  logic                timeout_q, timeout_d;
  logic [1:0]          cause_q, cause_d;

`ifdef BTN_SYNC_EN
  logic [1:0] btn_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_sync_q <= 2'b00;
    end else begin
      btn_sync_q <= {btn_sync_q[0], btn};
    end
  end

  assign btn_src = btn_sync_q[1];
`else
  assign btn_src = btn;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lights_q     <= '0;
      btn_q        <= 1'b0;
      btn_prev_q   <= 1'b0;
      level_prev_q <= 4'd0;
    end else begin
      lights_q     <= lights_in;
      btn_q        <= btn_src;
      btn_prev_q   <= btn_q;
      level_prev_q <= level;
    end
  end

  // A legal thermometer code has no lit bit above an unlit one.
  logic [N_LIGHTS-1:0] hole;
  logic                code_legal;
  logic [3:0]          lit_count;

  assign hole[0] = 1'b0;
  for (genvar gi = 1; gi < N_LIGHTS; gi++) begin : g_hole
    assign hole[gi] = lights_q[gi] & ~lights_q[gi-1];
  end
  assign code_legal = ~|hole;

  always_comb begin
    lit_count = 4'd0;
    for (int i = 0; i < N_LIGHTS; i++) begin
      lit_count = lit_count + 4'(lights_q[i]);
    end
  end

  assign level = code_legal ? lit_count : 4'd0;

  logic btn_rise;
  logic lvl_change;
  logic lvl_step;

  assign btn_rise   = btn_q & ~btn_prev_q;
  assign lvl_change = (level != level_prev_q);
  assign lvl_step   = (level == level_prev_q + 4'd1);

  // Priority within every active state: illegal code, then button edge, then level change.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    cause_d   = cause_q;
    case (state_q)
      S_IDLE: begin
        if (!code_legal) begin
          state_d = S_FAULT;
          cause_d = CAUSE_CODE;
        end else if (level == 4'd1) begin
          state_d = S_ARMING;
        end else if (level != 4'd0) begin
          state_d = S_FAULT;
          cause_d = CAUSE_SEQ;
        end
      end
      S_ARMING: begin
        if (!code_legal) begin
          state_d = S_FAULT;
          cause_d = CAUSE_CODE;
        end else if (btn_rise) begin
          state_d = S_FAULT;
          cause_d = CAUSE_JUMP;
        end else if (lvl_change) begin
          if (!lvl_step) begin
            state_d = S_FAULT;
            cause_d = CAUSE_SEQ;
          end else if (level == LVL_FULL) begin
            state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (!code_legal) begin
          state_d = S_FAULT;
          cause_d = CAUSE_CODE;
        end else if (btn_rise) begin
          // A press registered together with lights-out is a zero-cycle reaction.
          if (level == 4'd0) begin
            state_d   = S_DONE;
            result_d  = '0;
            timeout_d = 1'b0;
          end else begin
            state_d = S_FAULT;
            cause_d = CAUSE_JUMP;
          end
        end else if (lvl_change) begin
          if (level == 4'd0) begin
            state_d = S_TIMING;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = S_FAULT;
            cause_d = CAUSE_SEQ;
          end
        end
      end
      S_TIMING: begin
        if (!code_legal) begin
          state_d = S_FAULT;
          cause_d = CAUSE_CODE;
        end else if (btn_rise) begin
          state_d   = S_DONE;
          result_d  = cnt_q;
          timeout_d = 1'b0;
        end else if (lvl_change) begin
          state_d = S_FAULT;
          cause_d = CAUSE_SEQ;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = S_DONE;
          result_d  = CNT_MAX;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        if (ack) begin
          state_d   = S_IDLE;
          result_d  = '0;
          timeout_d = 1'b0;
          cnt_d     = '0;
        end
      end
      S_FAULT: begin
        if (ack) begin
          state_d = S_IDLE;
          cause_d = CAUSE_NONE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        result_d  = '0;
        timeout_d = 1'b0;
        cause_d   = CAUSE_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      cause_q   <= cause_d;
    end
  end

  assign busy         = (state_q == S_ARMING) || (state_q == S_FULL) || (state_q == S_TIMING);
  assign result       = result_q;
  assign result_valid = (state_q == S_DONE);
  assign timeout      = timeout_q;
  assign err          = (state_q == S_FAULT);
  assign err_cause    = cause_q;

endmodule

// File: tb/tb_f1_light_monitor.sv
// Bench for f1_light_monitor: a 16-bit and a 4-bit counter instance share stimulus; a scoreboard checks each result/fault event.
`timescale 1ns/1ps
module tb_f1_light_monitor;
`ifdef BTN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] lights = 8'd0;
  logic       btn = 1'b0;
  logic       ack = 1'b0;

  logic [3:0]  level, level4;
  logic        busy, busy4;
  logic [15:0] result;
  logic [3:0]  result4;
  logic        rv, rv4, to, to4, err, err4;
  logic [1:0]  cause, cause4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  f1_light_monitor #(.N_LIGHTS(8), .TIME_W(16)) dut (
    .clk(clk), .rst(rst), .lights_in(lights), .btn(btn), .ack(ack),
    .level(level), .busy(busy), .result(result), .result_valid(rv),
    .timeout(to), .err(err), .err_cause(cause)
  );

  f1_light_monitor #(.N_LIGHTS(8), .TIME_W(4)) dut4 (
    .clk(clk), .rst(rst), .lights_in(lights), .btn(btn), .ack(ack),
    .level(level4), .busy(busy4), .result(result4), .result_valid(rv4),
    .timeout(to4), .err(err4), .err_cause(cause4)
  );

  typedef struct packed {
    logic        err;
    logic [1:0]  cause;
    logic        to;
    logic [15:0] res;
  } ev_t;

  ev_t exp_q[$];
  ev_t exp4_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk(input logic e, input logic [1:0] c, input logic t, input int r);
    ev_t v;
    v.err   = e;
    v.cause = c;
    v.to    = t;
    v.res   = 16'(r);
    return v;
  endfunction

  function automatic logic [7:0] therm(input int k);
    return 8'((1 << k) - 1);
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill(input int from, input int upto, input int hold);
    for (int k = from; k <= upto; k++) begin
      lights = therm(k);
      cyc(hold);
    end
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(1);
  endtask

  task automatic push_both(input ev_t e);
    exp_q.push_back(e);
    exp4_q.push_back(e);
  endtask

  // Scoreboard: each rising edge of result_valid|err is one transaction.
  logic ev_prev = 1'b0;
  logic ev4_prev = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      ev_prev  = 1'b0;
      ev4_prev = 1'b0;
    end else begin
      if ((rv || err) && !ev_prev) begin
        $display("event dut16: err=%0b cause=%0d timeout=%0b result=%0d", err, cause, to, result);
        if (exp_q.size() == 0) begin
          chk("sb16_unexpected", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sb16_err", 32'(err), 32'(e.err));
          chk("sb16_valid", 32'(rv), 32'(!e.err));
          chk("sb16_cause", 32'(cause), 32'(e.cause));
          chk("sb16_timeout", 32'(to), 32'(e.to));
          chk("sb16_result", 32'(result), 32'(e.res));
        end
      end
      ev_prev = rv || err;
      if ((rv4 || err4) && !ev4_prev) begin
        $display("event dut4: err=%0b cause=%0d timeout=%0b result=%0d", err4, cause4, to4, result4);
        if (exp4_q.size() == 0) begin
          chk("sb4_unexpected", 32'(1), 32'(0));
        end else begin
          e = exp4_q.pop_front();
          chk("sb4_err", 32'(err4), 32'(e.err));
          chk("sb4_valid", 32'(rv4), 32'(!e.err));
          chk("sb4_cause", 32'(cause4), 32'(e.cause));
          chk("sb4_timeout", 32'(to4), 32'(e.to));
          chk("sb4_result", 32'(result4), 32'(e.res[3:0]));
        end
      end
      ev4_prev = rv4 || err4;
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_valid", 32'(rv), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    cyc(3);

    // Legal fill, lights-out, press 37 cycles later
    fill(1, 8, 3);
    chk("t1_level_full", 32'(level), 32'(8));
    chk("t1_busy_full", 32'(busy), 32'(1));
    lights = 8'd0;
    exp4_q.push_back(mk(1'b0, 2'b00, 1'b1, 15));
    cyc(37);
    btn = 1'b1;
    exp_q.push_back(mk(1'b0, 2'b00, 1'b0, 37 + LAT));
    cyc(1 + LAT);
    chk("t1_valid_early", 32'(rv), 32'(0));
    cyc(1);
    chk("t1_valid", 32'(rv), 32'(1));
    chk("t1_result", 32'(result), 32'(37 + LAT));
    chk("t1_err", 32'(err), 32'(0));
    chk("t1_to4", 32'(to4), 32'(1));
    btn = 1'b0;
    ack_pulse();
    chk("t1_ack_valid", 32'(rv), 32'(0));
    chk("t1_ack_result", 32'(result), 32'(0));
    chk("t1_ack_to4", 32'(to4), 32'(0));

    // Jump start at level 5
    fill(1, 5, 2);
    chk("t2_level5", 32'(level), 32'(5));
    btn = 1'b1;
    push_both(mk(1'b1, 2'b11, 1'b0, 0));
    cyc(3 + LAT);
    chk("t2_err", 32'(err), 32'(1));
    chk("t2_cause", 32'(cause), 32'(3));
    chk("t2_busy", 32'(busy), 32'(0));
    btn = 1'b0;
    lights = 8'd0;
    cyc(1);
    ack_pulse();
    chk("t2_ack_err", 32'(err), 32'(0));
    chk("t2_ack_cause", 32'(cause), 32'(0));
    chk("t2_ack_busy", 32'(busy), 32'(0));

    // Level jump 3 -> 5
    fill(1, 3, 2);
    lights = therm(5);
    push_both(mk(1'b1, 2'b10, 1'b0, 0));
    cyc(3);
    chk("t3a_cause", 32'(cause), 32'(2));
    lights = 8'd0;
    cyc(1);
    ack_pulse();

    // Illegal thermometer code during arming
    fill(1, 2, 2);
    lights = 8'b0000_0101;
    push_both(mk(1'b1, 2'b01, 1'b0, 0));
    cyc(1);
    chk("t3b_level_illegal", 32'(level), 32'(0));
    cyc(2);
    chk("t3b_cause", 32'(cause), 32'(1));
    lights = 8'd0;
    cyc(1);
    ack_pulse();

    // Idle sees level 2 directly
    lights = therm(2);
    push_both(mk(1'b1, 2'b10, 1'b0, 0));
    cyc(3);
    chk("t3c_cause", 32'(cause), 32'(2));
    lights = 8'd0;
    cyc(1);
    ack_pulse();

    // Saturation on the 4-bit instance, no press
    fill(1, 8, 2);
    lights = 8'd0;
    exp4_q.push_back(mk(1'b0, 2'b00, 1'b1, 15));
    cyc(16);
    chk("t4_valid4_early", 32'(rv4), 32'(0));
    cyc(1);
    chk("t4_valid4", 32'(rv4), 32'(1));
    chk("t4_timeout4", 32'(to4), 32'(1));
    chk("t4_result4", 32'(result4), 32'(15));
    chk("t4_busy16", 32'(busy), 32'(1));
    cyc(13);
    btn = 1'b1;
    exp_q.push_back(mk(1'b0, 2'b00, 1'b0, 30 + LAT));
    cyc(3 + LAT);
    chk("t4_result16", 32'(result), 32'(30 + LAT));
    chk("t4_timeout16", 32'(to), 32'(0));
    btn = 1'b0;
    ack_pulse();

    // Press lands exactly at the 4-bit maximum
    fill(1, 8, 2);
    lights = 8'd0;
    cyc(15 - LAT);
    btn = 1'b1;
    push_both(mk(1'b0, 2'b00, 1'b0, 15));
    cyc(3 + LAT);
    chk("t4b_result4", 32'(result4), 32'(15));
    chk("t4b_timeout4", 32'(to4), 32'(0));
    btn = 1'b0;
    ack_pulse();

    // Asynchronous reset while timing
    fill(1, 8, 2);
    lights = 8'd0;
    cyc(5);
    chk("t5_busy_pre", 32'(busy), 32'(1));
    #2;
    rst = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_busy4", 32'(busy4), 32'(0));
    chk("t5_valid", 32'(rv), 32'(0));
    chk("t5_err", 32'(err), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    cyc(2);

    // Ack ignored while arming; press on the lights-out edge
    fill(1, 4, 2);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("t6_ack_ignored", 32'(busy), 32'(1));
    fill(5, 8, 2);
    lights = 8'd0;
    btn = 1'b1;
    push_both(mk(1'b0, 2'b00, 1'b0, LAT));
    cyc(3 + LAT);
    chk("t6_valid", 32'(rv), 32'(1));
    chk("t6_result", 32'(result), 32'(LAT));
    chk("t6_err", 32'(err), 32'(0));
    btn = 1'b0;
    ack_pulse();

    cyc(3);
    chk("sb16_pending", 32'(exp_q.size()), 32'(0));
    chk("sb4_pending", 32'(exp4_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
